// File: rtl/potential_decay_scheduler.sv
// Membrane-potential decay sweep: read, decay through an external unit, write back, per neuron.
// Optional DECAY_SKIP_ZERO_EN: neurons holding +0.0/-0.0 skip the decay and write-back.
module potential_decay_scheduler #(
  parameter int unsigned NUM_NEURONS   = 10,
  parameter int unsigned IDX_W         = 4,
  parameter int unsigned DECAY_LATENCY = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             timestep_start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             overrun_o,
  output logic             mem_rd_en_o,
  output logic [IDX_W-1:0] mem_rd_addr_o,
  input  logic [31:0]      mem_rd_data_i,
  output logic             mem_wr_en_o,
  output logic [IDX_W-1:0] mem_wr_addr_o,
  output logic [31:0]      mem_wr_data_o,
  input  logic             mem_wr_ready_i,
  input  logic             rate_wr_en_i,
  input  logic [IDX_W-1:0] rate_wr_idx_i,
  input  logic [2:0]       rate_wr_data_i,
  output logic             decay_clear_o,
  output logic [2:0]       decay_rate_o,
  output logic [31:0]      decay_in_o,
  input  logic [31:0]      decay_out_i
);

  localparam int unsigned      CntW    = (DECAY_LATENCY > 1) ? $clog2(DECAY_LATENCY + 1) : 1;
  localparam logic [CntW-1:0]  CntLoad = CntW'(DECAY_LATENCY);
  localparam logic [CntW-1:0]  CntOne  = CntW'(1);
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_NEURONS - 1);

  typedef enum logic [2:0] {StIdle, StRead, StLoad, StDecay, StWrite, StDone} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             overrun_q, overrun_d;
  logic [IDX_W-1:0] rd_addr_q, rd_addr_d;
  logic [IDX_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]      wr_data_q, wr_data_d;
  logic [31:0]      decay_in_q, decay_in_d;
  logic [2:0]       decay_rate_q, decay_rate_d;
  logic [2:0]       rate_table_q [NUM_NEURONS];
  logic [2:0]       rate_table_d [NUM_NEURONS];

  logic skip;
  logic last;
  logic advance;

`ifdef DECAY_SKIP_ZERO_EN
  // Sign bit ignored so that both +0.0 and -0.0 are skipped.
  assign skip = (mem_rd_data_i[30:0] == 31'd0);
`else
  assign skip = 1'b0;
`endif

  assign last    = (idx_q == LastIdx);
  assign advance = ((state_q == StLoad) && skip) || ((state_q == StWrite) && mem_wr_ready_i);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (timestep_start_i) state_d = StRead;
      StRead:  state_d = StLoad;
      StLoad:  state_d = skip ? (last ? StDone : StRead) : StDecay;
      StDecay: if (cnt_q == CntOne) state_d = StWrite;
      StWrite: if (mem_wr_ready_i) state_d = last ? StDone : StRead;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy_o        = (state_q != StIdle);
    done_o        = (state_q == StDone);
    mem_rd_en_o   = (state_q == StRead);
    mem_wr_en_o   = (state_q == StWrite);
    decay_clear_o = (state_q == StLoad) && !skip;
  end

  always_comb begin
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    overrun_d    = overrun_q;
    rd_addr_d    = rd_addr_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    decay_in_d   = decay_in_q;
    decay_rate_d = decay_rate_q;
    rate_table_d = rate_table_q;

    // An accepted start clears the flag; a start seen anywhere else sets it.
    if (timestep_start_i) overrun_d = (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        if (timestep_start_i) begin
          idx_d     = '0;
          rd_addr_d = '0;
        end
      end
      StLoad: begin
        if (!skip) begin
          decay_in_d   = mem_rd_data_i;
          decay_rate_d = rate_table_q[idx_q];
          cnt_d        = CntLoad;
        end
      end
      StDecay: begin
        cnt_d = cnt_q - CntOne;
        if (cnt_q == CntOne) begin
          wr_data_d = decay_out_i;
          wr_addr_d = idx_q;
        end
      end
      default: ;
    endcase

    if (advance && !last) begin
      idx_d     = idx_q + 1'b1;
      rd_addr_d = idx_q + 1'b1;
    end

    for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
      if (rate_wr_en_i && (rate_wr_idx_i == IDX_W'(i))) rate_table_d[i] = rate_wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      idx_q        <= '0;
      cnt_q        <= '0;
      overrun_q    <= 1'b0;
      rd_addr_q    <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      decay_in_q   <= '0;
      decay_rate_q <= '0;
      for (int unsigned i = 0; i < NUM_NEURONS; i++) rate_table_q[i] <= 3'd1;
    end else begin
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      overrun_q    <= overrun_d;
      rd_addr_q    <= rd_addr_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      decay_in_q   <= decay_in_d;
      decay_rate_q <= decay_rate_d;
      rate_table_q <= rate_table_d;
    end
  end

  assign overrun_o     = overrun_q;
  assign mem_rd_addr_o = rd_addr_q;
  assign mem_wr_addr_o = wr_addr_q;
  assign mem_wr_data_o = wr_data_q;
  assign decay_in_o    = decay_in_q;
  assign decay_rate_o  = decay_rate_q;

endmodule

// File: tb/tb_potential_decay_scheduler.sv
// Directed plus randomized bench for potential_decay_scheduler with a memory and decay-unit stub.
module tb_potential_decay_scheduler;

  localparam int N = 10;
  localparam int L = 2;
  localparam logic [31:0] Ten  = 32'h4120_0000;
  localparam logic [31:0] Five = 32'h40A0_0000;

  logic        clk = 1'b0;
  logic        reset, timestep_start;
  logic        busy, done, overrun;
  logic        mem_rd_en, mem_wr_en, mem_wr_ready;
  logic [3:0]  mem_rd_addr, mem_wr_addr;
  logic [31:0] mem_rd_data, mem_wr_data;
  logic        rate_wr_en;
  logic [3:0]  rate_wr_idx;
  logic [2:0]  rate_wr_data;
  logic        decay_clear;
  logic [2:0]  decay_rate;
  logic [31:0] decay_in, decay_out;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem   [N];
  logic [31:0] mem_m [N];
  logic [2:0]  rate_m[N];
  logic [35:0] wq[$];

  // Sweep controls and results
  int stall_idx, stall_len, start2_at;
  bit rnd_ready, midrate;
  int done_cyc, stalls, busy_bad, hold_cnt, hold_bad;
  logic [31:0] hold_data;
  logic ovr_at1, ovr_mid;

  always #5 clk = ~clk;

  potential_decay_scheduler #(
    .NUM_NEURONS  (N),
    .IDX_W        (4),
    .DECAY_LATENCY(L)
  ) dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .timestep_start_i(timestep_start),
    .busy_o          (busy),
    .done_o          (done),
    .overrun_o       (overrun),
    .mem_rd_en_o     (mem_rd_en),
    .mem_rd_addr_o   (mem_rd_addr),
    .mem_rd_data_i   (mem_rd_data),
    .mem_wr_en_o     (mem_wr_en),
    .mem_wr_addr_o   (mem_wr_addr),
    .mem_wr_data_o   (mem_wr_data),
    .mem_wr_ready_i  (mem_wr_ready),
    .rate_wr_en_i    (rate_wr_en),
    .rate_wr_idx_i   (rate_wr_idx),
    .rate_wr_data_i  (rate_wr_data),
    .decay_clear_o   (decay_clear),
    .decay_rate_o    (decay_rate),
    .decay_in_o      (decay_in),
    .decay_out_i     (decay_out)
  );

  // Decay stub: scale by 2^-rate via the exponent (10.0 at rate 1 -> 5.0).
  function automatic logic [31:0] decay_f(input logic [31:0] p, input logic [2:0] r);
    return {p[31], p[30:23] - {5'd0, r}, p[22:0]};
  endfunction

  function automatic bit is_skip(input logic [31:0] p);
`ifdef DECAY_SKIP_ZERO_EN
    return p[30:0] == 31'd0;
`else
    return 1'b0 && p[0];
`endif
  endfunction

  assign decay_out = decay_f(decay_in, decay_rate);

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= (mem_rd_addr < 4'(N)) ? mem[mem_rd_addr] : 32'hDEAD_BEEF;
    if (mem_wr_en && mem_wr_ready) begin
      wq.push_back({mem_wr_addr, mem_wr_data});
      if (mem_wr_addr < 4'(N)) mem[mem_wr_addr] <= mem_wr_data;
    end
  end

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_all(input logic [31:0] v);
    for (int i = 0; i < N; i++) begin
      mem[i]   = v;
      mem_m[i] = v;
    end
  endtask

  task automatic load_random();
    for (int i = 0; i < N; i++) begin
      mem[i] = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 200)), 23'($urandom)};
      mem_m[i] = mem[i];
    end
  endtask

  function automatic int exp_done(input int nstall);
    int t = 1 + nstall;
    for (int i = 0; i < N; i++) t += is_skip(mem_m[i]) ? 2 : 3 + L;
    return t;
  endfunction

  task automatic check_writes(input string tag);
    logic [35:0] e[$];
    for (int i = 0; i < N; i++)
      if (!is_skip(mem_m[i])) e.push_back({4'(i), decay_f(mem_m[i], rate_m[i])});
    chk({tag, "_nwrites"}, 36'(wq.size()), 36'(e.size()));
    for (int i = 0; i < e.size() && i < wq.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), wq[i], e[i]);
    foreach (e[i]) mem_m[e[i][35:32]] = e[i][31:0];
  endtask

  task automatic run_sweep();
    int mid_ph = 0;
    done_cyc = -1; stalls = 0; busy_bad = 0; hold_cnt = 0; hold_bad = 0;
    ovr_at1 = 1'bx; ovr_mid = 1'bx;
    wq.delete();
    timestep_start = 1'b1;
    @(negedge clk);
    timestep_start = 1'b0;
    for (int n = 1; n <= 600; n++) begin
      if (n == 1) ovr_at1 = overrun;
      if (n == start2_at + 1) ovr_mid = overrun;
      if (busy !== 1'b1) busy_bad++;
      if (done === 1'b1) begin
        done_cyc = n;
        break;
      end
      if (mem_wr_en && int'(mem_wr_addr) == stall_idx) begin
        if (hold_cnt == 0) hold_data = mem_wr_data;
        else if (mem_wr_data !== hold_data) hold_bad++;
        hold_cnt++;
      end
      mem_wr_ready = 1'b1;
      if (mem_wr_en && int'(mem_wr_addr) == stall_idx && stalls < stall_len) begin
        mem_wr_ready = 1'b0;
        stalls++;
      end else if (rnd_ready && mem_wr_en && $urandom_range(0, 3) == 0) begin
        mem_wr_ready = 1'b0;
        stalls++;
      end
      timestep_start = (n == start2_at);
      rate_wr_en = 1'b0;
      if (midrate) begin
        if (mid_ph == 2) begin
          rate_wr_en = 1'b1; rate_wr_idx = 4'd2; rate_wr_data = 3'd6; mid_ph = 3;
        end else if (mid_ph == 1 && decay_clear && mem_rd_addr == 4'd2) begin
          rate_wr_en = 1'b1; rate_wr_idx = 4'd12; rate_wr_data = 3'd5; mid_ph = 2;
        end else if (mid_ph == 0 && mem_rd_en && mem_rd_addr == 4'd2) begin
          rate_wr_en = 1'b1; rate_wr_idx = 4'd7; rate_wr_data = 3'd3; mid_ph = 1;
        end
      end
      @(negedge clk);
    end
    timestep_start = 1'b0;
    rate_wr_en     = 1'b0;
    mem_wr_ready   = 1'b1;
    @(negedge clk);
    chk("done_one_cycle", 36'(done), 36'(0));
    chk("busy_after_done", 36'(busy), 36'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 36'(busy), 36'(0));
    chk({tag, "_done"}, 36'(done), 36'(0));
    chk({tag, "_overrun"}, 36'(overrun), 36'(0));
    chk({tag, "_en"}, 36'({mem_rd_en, mem_wr_en, decay_clear}), 36'(0));
    chk({tag, "_addr"}, 36'({mem_rd_addr, mem_wr_addr}), 36'(0));
    chk({tag, "_rate"}, 36'(decay_rate), 36'(0));
    chk({tag, "_decay_in"}, 36'(decay_in), 36'(0));
    chk({tag, "_wr_data"}, 36'(mem_wr_data), 36'(0));
  endtask

  initial begin
    int d_exp, wr5, ndone, nwr;
    bit found;
    reset = 1'b1; timestep_start = 1'b0; mem_wr_ready = 1'b1;
    rate_wr_en = 1'b0; rate_wr_idx = '0; rate_wr_data = '0;
    stall_idx = -1; stall_len = 0; start2_at = -10; rnd_ready = 1'b0; midrate = 1'b0;
    for (int i = 0; i < N; i++) rate_m[i] = 3'd1;
    load_all(Ten);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_reset_outputs("reset");

    // Single sweep, all 10.0, default rates
    run_sweep();
    chk("single_done_cycle", 36'(done_cyc), 36'(exp_done(0)));
    chk("single_done_51", 36'(done_cyc), 36'(51));
    chk("single_busy", 36'(busy_bad), 36'(0));
    check_writes("single");

    // Backpressure: 3 stall cycles on neuron 4
    load_all(Ten);
    stall_idx = 4; stall_len = 3;
    run_sweep();
    chk("bp_done_cycle", 36'(done_cyc), 36'(54));
    chk("bp_hold_cycles", 36'(hold_cnt), 36'(4));
    chk("bp_hold_stable", 36'(hold_bad), 36'(0));
    check_writes("bp");
    stall_idx = -1; stall_len = 0;

    // Overrun: second start 5 cycles into the sweep
    load_all(Ten);
    start2_at = 5;
    run_sweep();
    chk("ovr_set", 36'(ovr_mid), 36'(1));
    chk("ovr_done_cycle", 36'(done_cyc), 36'(51));
    check_writes("ovr");
    chk("ovr_sticky", 36'(overrun), 36'(1));
    start2_at = -10;

    // Mid-sweep rate writes: idx 7 -> 3, idx 12 ignored, idx 2 -> 6 during its own decay
    load_random();
    midrate = 1'b1;
    rate_m[7] = 3'd3;
    run_sweep();
    chk("ovr_cleared", 36'(ovr_at1), 36'(0));
    chk("rate_done_cycle", 36'(done_cyc), 36'(exp_done(0)));
    check_writes("rate");
    rate_m[2] = 3'd6;
    midrate = 1'b0;

    // Randomized sweeps with random rate writes and random backpressure
    rnd_ready = 1'b1;
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < 6; k++) begin
        rate_wr_en   = 1'b1;
        rate_wr_idx  = 4'($urandom_range(0, 15));
        rate_wr_data = 3'($urandom_range(0, 7));
        if (int'(rate_wr_idx) < N) rate_m[rate_wr_idx] = rate_wr_data;
        @(negedge clk);
      end
      rate_wr_en = 1'b0;
      load_random();
      run_sweep();
      chk($sformatf("rnd%0d_done_cycle", s), 36'(done_cyc), 36'(exp_done(stalls)));
      chk($sformatf("rnd%0d_busy", s), 36'(busy_bad), 36'(0));
      check_writes($sformatf("rnd%0d", s));
    end
    rnd_ready = 1'b0;

`ifdef DECAY_SKIP_ZERO_EN
    load_all(Ten);
    mem[3] = 32'h8000_0000; mem_m[3] = 32'h8000_0000;
    run_sweep();
    chk("skip_done_cycle", 36'(done_cyc), 36'(exp_done(0) + 0));
    chk("skip_done_48", 36'(done_cyc), 36'(1 + 9 * (3 + L) + 2));
    check_writes("skip");
`endif

    // Reset while neuron 5 is in DECAY
    load_all(Ten);
    wq.delete();
    found = 1'b0;
    timestep_start = 1'b1;
    @(negedge clk);
    timestep_start = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (decay_clear && mem_rd_addr == 4'd5) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("rst_reached_load5", 36'(found), 36'(1));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_outputs("midrst");
    ndone = 0;
    for (int n = 0; n < 20; n++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    wr5 = 0;
    nwr = wq.size();
    foreach (wq[i]) if (wq[i][35:32] == 4'd5) wr5++;
    chk("midrst_no_write5", 36'(wr5), 36'(0));
    chk("midrst_writes", 36'(nwr), 36'(5));
    chk("midrst_no_done", 36'(ndone), 36'(0));

    // Rate table back to 1 after reset
    for (int i = 0; i < N; i++) rate_m[i] = 3'd1;
    load_all(Ten);
    run_sweep();
    chk("post_rst_done_cycle", 36'(done_cyc), 36'(exp_done(0)));
    d_exp = (wq.size() > 9) ? 1 : 0;
    chk("post_rst_full", 36'(d_exp), 36'(1));
    if (wq.size() > 9) chk("post_rst_w9", 36'(wq[9][31:0]), 36'(Five));
    check_writes("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
